vga_timing_generator: RTL and testbench

Parametrised VGA raster timing generator for the display pipeline, replacing the fixed 640x480 clock-divider-plus-scanline-driver pair. Derives a pixel clock enable from the core clock and produces horizontal/vertical counters, sync pulses, draw enable and frame/line markers. Resolution, porches, sync polarity, pixel divide ratio and output alignment delay are all parameters. Feeds the image driver (coordinates, draw enable) and the VGA DAC (delayed sync/enable).

---
 rtl/vga_timing_generator.sv | 194 +++++++++++++++++++
 tb/tb_vga_timing_generator.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: parametrised raster timing for the display pipeline.
// A core-clock divider produces the pixel tick; on every tick the registered
// outputs load the decode of the current (h, v) position and the position then
// advances. Sync/DE copies for the DAC are delayed PIPE ticks behind.
module vga_timing_generator #(
   parameter int   H_ACTIVE  = 640,
   parameter int   H_FRONT   = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BACK    = 48,
   parameter int   V_ACTIVE  = 480,
   parameter int   V_FRONT   = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BACK    = 33,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   PIX_DIV   = 2,
   parameter int   PIPE      = 2
) (
   input  logic                          i_CLK,
   input  logic                          i_RST,
   input  logic                          i_BLANK,
   output logic                          o_PIX_CE,
   output logic                          o_HSYNC,
   output logic                          o_VSYNC,
   output logic                          o_DE,
   output logic [$clog2(H_ACTIVE)-1:0]   o_X,
   output logic [$clog2(V_ACTIVE)-1:0]   o_Y,
   output logic                          o_LINE_START,
   output logic                          o_FRAME_START,
   output logic                          o_HSYNC_D,
   output logic                          o_VSYNC_D,
   output logic                          o_DE_D
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int XW      = $clog2(H_ACTIVE);
   localparam int YW      = $clog2(V_ACTIVE);
   localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   // Position boundaries sized to the counters so comparisons stay width-exact.
   localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FRONT);
   localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FRONT);
   localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
   localparam logic [DW-1:0] DIV_LAST_C = DW'(PIX_DIV - 1);

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          blank_frame_q, blank_frame_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic          pix_ce;
   logic          at_origin;
   logic          active;

   // Pixel divider and raster position advance.
   always_comb begin
      pix_ce    = (div_cnt_q == DIV_LAST_C);
      div_cnt_d = pix_ce ? '0 : div_cnt_q + 1'b1;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      if (pix_ce) begin
         if (h_cnt_q == H_LAST_C) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

   // Decode of the current position, loaded into the outputs on each tick.
   // The blank flag is captured at the origin and already applies to the DE
   // loaded on that same tick, so a frame is blanked from its first pixel.
   always_comb begin
      at_origin     = (h_cnt_q == '0) && (v_cnt_q == '0);
      active        = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
      blank_frame_d = blank_frame_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      de_d          = de_q;
      x_d           = x_q;
      y_d           = y_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (pix_ce) begin
         if (at_origin) blank_frame_d = i_BLANK;
         hsync_d = ((h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C)) ? HSYNC_POL : ~HSYNC_POL;
         vsync_d = ((v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C)) ? VSYNC_POL : ~VSYNC_POL;
         de_d    = active & ~blank_frame_d;
         x_d     = active ? h_cnt_q[XW-1:0] : '0;
         y_d     = active ? v_cnt_q[YW-1:0] : '0;
         line_start_d  = (h_cnt_q == '0);
         frame_start_d = at_origin;
      end
   end

   // State and output registers.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         div_cnt_q     <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         blank_frame_q <= 1'b0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         de_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         blank_frame_q <= blank_frame_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   // The tick is held low while reset is applied (matters when PIX_DIV = 1).
   assign o_PIX_CE      = pix_ce & ~i_RST;
   assign o_HSYNC       = hsync_q;
   assign o_VSYNC       = vsync_q;
   assign o_DE          = de_q;
   assign o_X           = x_q;
   assign o_Y           = y_q;
   assign o_LINE_START  = line_start_q;
   assign o_FRAME_START = frame_start_q;

   if (PIPE == 0) begin : g_nopipe
      assign o_HSYNC_D = hsync_q;
      assign o_VSYNC_D = vsync_q;
      assign o_DE_D    = de_q;
   end else begin : g_pipe
      logic [PIPE-1:0] hs_pipe_q, hs_pipe_d;
      logic [PIPE-1:0] vs_pipe_q, vs_pipe_d;
      logic [PIPE-1:0] de_pipe_q, de_pipe_d;

      // Delay line shifts only on the pixel tick, so the lag is counted in ticks.
      always_comb begin
         hs_pipe_d = hs_pipe_q;
         vs_pipe_d = vs_pipe_q;
         de_pipe_d = de_pipe_q;
         if (pix_ce) begin
            hs_pipe_d[0] = hsync_q;
            vs_pipe_d[0] = vsync_q;
            de_pipe_d[0] = de_q;
            for (int i = 1; i < PIPE; i++) begin
               hs_pipe_d[i] = hs_pipe_q[i-1];
               vs_pipe_d[i] = vs_pipe_q[i-1];
               de_pipe_d[i] = de_pipe_q[i-1];
            end
         end
      end

      // Delay stages reset to the inactive sync level and DE low.
      always_ff @(posedge i_CLK or posedge i_RST) begin
         if (i_RST) begin
            hs_pipe_q <= {PIPE{~HSYNC_POL}};
            vs_pipe_q <= {PIPE{~VSYNC_POL}};
            de_pipe_q <= '0;
         end else begin
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            de_pipe_q <= de_pipe_d;
         end
      end

      assign o_HSYNC_D = hs_pipe_q[PIPE-1];
      assign o_VSYNC_D = vs_pipe_q[PIPE-1];
      assign o_DE_D    = de_pipe_q[PIPE-1];
   end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: three configurations (default 640x480,
// a mid-size raster with PIPE=3, and a tiny raster with PIX_DIV=1) driven by a
// shared clock, reset and blank request. The model derives every output from
// the count of core clock edges since reset using plain raster arithmetic.
module tb_vga_timing_generator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic blank = 1'b0;

   always #5 clk = ~clk;

   // instance 0: defaults
   logic ce0, hs0, vs0, de0, ls0, fs0, hsd0, vsd0, ded0;
   logic [9:0] x0;
   logic [8:0] y0;
   // instance 1: mid-size raster, PIPE = 3, vsync active-high
   logic ce1, hs1, vs1, de1, ls1, fs1, hsd1, vsd1, ded1;
   logic [3:0] x1;
   logic [2:0] y1;
   // instance 2: tiny raster, PIX_DIV = 1, hsync active-high, PIPE = 0
   logic ce2, hs2, vs2, de2, ls2, fs2, hsd2, vsd2, ded2;
   logic [1:0] x2;
   logic [0:0] y2;

   vga_timing_generator u_dflt (
      .i_CLK(clk), .i_RST(rst), .i_BLANK(blank), .o_PIX_CE(ce0),
      .o_HSYNC(hs0), .o_VSYNC(vs0), .o_DE(de0), .o_X(x0), .o_Y(y0),
      .o_LINE_START(ls0), .o_FRAME_START(fs0),
      .o_HSYNC_D(hsd0), .o_VSYNC_D(vsd0), .o_DE_D(ded0));

   vga_timing_generator #(
      .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .PIX_DIV(2), .PIPE(3)
   ) u_mid (
      .i_CLK(clk), .i_RST(rst), .i_BLANK(blank), .o_PIX_CE(ce1),
      .o_HSYNC(hs1), .o_VSYNC(vs1), .o_DE(de1), .o_X(x1), .o_Y(y1),
      .o_LINE_START(ls1), .o_FRAME_START(fs1),
      .o_HSYNC_D(hsd1), .o_VSYNC_D(vsd1), .o_DE_D(ded1));

   vga_timing_generator #(
      .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
      .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIX_DIV(1), .PIPE(0)
   ) u_tiny (
      .i_CLK(clk), .i_RST(rst), .i_BLANK(blank), .o_PIX_CE(ce2),
      .o_HSYNC(hs2), .o_VSYNC(vs2), .o_DE(de2), .o_X(x2), .o_Y(y2),
      .o_LINE_START(ls2), .o_FRAME_START(fs2),
      .o_HSYNC_D(hsd2), .o_VSYNC_D(vsd2), .o_DE_D(ded2));

   // configuration table, one column per instance
   int p_ha[3]   = '{640, 16, 4};
   int p_hf[3]   = '{16, 2, 1};
   int p_hs[3]   = '{96, 3, 1};
   int p_hb[3]   = '{48, 3, 1};
   int p_va[3]   = '{480, 6, 2};
   int p_vf[3]   = '{10, 1, 1};
   int p_vs[3]   = '{2, 2, 1};
   int p_vb[3]   = '{33, 1, 1};
   int p_hp[3]   = '{0, 0, 1};
   int p_vp[3]   = '{0, 1, 0};
   int p_div[3]  = '{2, 2, 1};
   int p_pipe[3] = '{2, 3, 0};

   int checks = 0;
   int failures = 0;
   int k_cnt = 0;           // core clock edges since reset released
   bit blank_hist[3][64];   // blank request seen at each frame's first tick

   function automatic int h_tot(input int i);
      return p_ha[i] + p_hf[i] + p_hs[i] + p_hb[i];
   endfunction

   function automatic int v_tot(input int i);
      return p_va[i] + p_vf[i] + p_vs[i] + p_vb[i];
   endfunction

   // Outputs for linear tick position p (p < 0 means "nothing loaded yet").
   function automatic void decode(input int i, input int p, output bit hs, output bit vs,
                                  output bit de, output int x, output int y);
      int h, v, f;
      bit act;
      if (p < 0) begin
         hs = (p_hp[i] == 0);
         vs = (p_vp[i] == 0);
         de = 1'b0;
         x = 0;
         y = 0;
      end else begin
         h = p % h_tot(i);
         v = (p / h_tot(i)) % v_tot(i);
         f = p / (h_tot(i) * v_tot(i));
         act = (h < p_ha[i]) && (v < p_va[i]);
         hs = ((h >= p_ha[i] + p_hf[i]) && (h < p_ha[i] + p_hf[i] + p_hs[i])) ? (p_hp[i] != 0) : (p_hp[i] == 0);
         vs = ((v >= p_va[i] + p_vf[i]) && (v < p_va[i] + p_vf[i] + p_vs[i])) ? (p_vp[i] != 0) : (p_vp[i] == 0);
         de = act && !blank_hist[i][f % 64];
         x = act ? h : 0;
         y = act ? v : 0;
      end
   endfunction

   task automatic check_one(input string name, input int inst, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 20)
            $display("FAIL %s inst%0d k=%0d actual=%0d expected=%0d", name, inst, k_cnt, act, exp);
      end
   endtask

   task automatic check_inst(input int i, input logic ce, input logic hs, input logic vs,
                             input logic de, input logic [31:0] x, input logic [31:0] y,
                             input logic ls, input logic fs, input logic hsd,
                             input logic vsd, input logic ded);
      int n, p, ex, ey, exd, eyd;
      bit e_ce, e_hs, e_vs, e_de, e_ls, e_fs, e_hsd, e_vsd, e_ded;
      if (rst) begin
         n = 0;
         e_ce = 1'b0;
      end else begin
         n = k_cnt / p_div[i];
         e_ce = ((k_cnt + 1) % p_div[i] == 0);
      end
      p = n - 1;
      decode(i, p, e_hs, e_vs, e_de, ex, ey);
      decode(i, p - p_pipe[i], e_hsd, e_vsd, e_ded, exd, eyd);
      e_ls = !rst && (n >= 1) && (k_cnt % p_div[i] == 0) && (p % h_tot(i) == 0);
      e_fs = e_ls && ((p / h_tot(i)) % v_tot(i) == 0);
      check_one("pix_ce", i, ce, e_ce);
      check_one("hsync", i, hs, e_hs);
      check_one("vsync", i, vs, e_vs);
      check_one("de", i, de, e_de);
      check_one("x", i, x, ex);
      check_one("y", i, y, ey);
      check_one("line_start", i, ls, e_ls);
      check_one("frame_start", i, fs, e_fs);
      check_one("hsync_d", i, hsd, e_hsd);
      check_one("vsync_d", i, vsd, e_vsd);
      check_one("de_d", i, ded, e_ded);
   endtask

   // model time base and per-frame blank capture, on the active edge
   always @(posedge clk) begin
      if (rst) begin
         k_cnt = 0;
         for (int i = 0; i < 3; i++)
            for (int f = 0; f < 64; f++) blank_hist[i][f] = 1'b0;
      end else begin
         k_cnt = k_cnt + 1;
         for (int i = 0; i < 3; i++) begin
            if (k_cnt % p_div[i] == 0) begin
               int pp, fl;
               pp = k_cnt / p_div[i] - 1;
               fl = h_tot(i) * v_tot(i);
               if (pp % fl == 0) blank_hist[i][(pp / fl) % 64] = blank;
            end
         end
      end
   end

   // every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      check_inst(0, ce0, hs0, vs0, de0, 32'(x0), 32'(y0), ls0, fs0, hsd0, vsd0, ded0);
      check_inst(1, ce1, hs1, vs1, de1, 32'(x1), 32'(y1), ls1, fs1, hsd1, vsd1, ded1);
      check_inst(2, ce2, hs2, vs2, de2, 32'(x2), 32'(y2), ls2, fs2, hsd2, vsd2, ded2);
   end

   task automatic go_to(input int target);
      int guard;
      guard = 0;
      while (k_cnt < target && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (k_cnt < target) check_one("timeout", 0, k_cnt, target);
   endtask

   // directed sequence with hand-computed expectations
   initial begin
      rst = 1'b1;
      blank = 1'b0;
      repeat (4) @(negedge clk);
      check_one("rst_hs", 0, hs0, 1);
      check_one("rst_hs", 2, hs2, 0);
      check_one("rst_ce", 2, ce2, 0);
      check_one("rst_vsd", 1, vsd1, 0);
      check_one("rst_ded", 1, ded1, 0);
      #2 rst = 1'b0;

      go_to(1);
      check_one("k1_fs", 2, fs2, 1);
      check_one("k1_ls", 2, ls2, 1);
      check_one("k1_de", 2, de2, 1);
      check_one("k1_hs", 2, hs2, 0);
      check_one("k1_ce", 2, ce2, 1);
      check_one("k1_fs", 1, fs1, 0);
      check_one("k1_hs", 1, hs1, 1);
      go_to(2);
      check_one("k2_fs", 1, fs1, 1);
      check_one("k2_fs", 0, fs0, 1);
      check_one("k2_ce", 1, ce1, 0);
      check_one("k2_de", 1, de1, 1);
      check_one("k2_ded", 1, ded1, 0);
      go_to(3);
      check_one("k3_fs", 1, fs1, 0);
      check_one("k3_ce", 1, ce1, 1);
      go_to(6);
      check_one("h5_hs", 2, hs2, 1);
      check_one("h5_de", 2, de2, 0);
      go_to(7);
      check_one("h6_hs", 2, hs2, 0);
      go_to(8);
      check_one("wrap_ls", 2, ls2, 1);
      check_one("wrap_fs", 2, fs2, 0);
      check_one("wrap_y", 2, y2, 1);
      check_one("wrap_x", 2, x2, 0);
      check_one("pipe3_ded", 1, ded1, 1);
      go_to(36);
      check_one("frame35_fs", 2, fs2, 1);
      go_to(337);
      check_one("v6_vs", 1, vs1, 0);
      go_to(338);
      check_one("v7_vs", 1, vs1, 1);
      check_one("v7_vsd", 1, vsd1, 0);
      go_to(344);
      check_one("v7_vsd_lag", 1, vsd1, 1);
      go_to(1280);
      check_one("x639", 0, x0, 639);
      check_one("de639", 0, de0, 1);
      go_to(1282);
      check_one("x640", 0, x0, 0);
      check_one("de640", 0, de0, 0);
      go_to(1313);
      check_one("h655_hs", 0, hs0, 1);
      go_to(1314);
      check_one("h656_hs", 0, hs0, 0);
      go_to(1505);
      check_one("h751_hs", 0, hs0, 0);
      go_to(1506);
      check_one("h752_hs", 0, hs0, 1);
      check_one("h752_hsd", 0, hsd0, 0);
      go_to(1602);
      check_one("line1_ls", 0, ls0, 1);
      check_one("line1_y", 0, y0, 1);
      check_one("line1_fs", 0, fs0, 0);

      go_to(1700);
      blank = 1'b1;
      go_to(1922);
      check_one("blank_fs", 1, fs1, 1);
      check_one("blank_de", 1, de1, 0);
      check_one("blank_cur_frame_de", 0, de0, 1);
      go_to(1924);
      check_one("blank_x", 1, x1, 1);
      check_one("blank_de2", 1, de1, 0);
      go_to(2100);
      blank = 1'b0;
      go_to(2258);
      check_one("blank_vs", 1, vs1, 1);
      go_to(2404);
      check_one("unblank_de", 1, de1, 1);
      check_one("unblank_x", 1, x1, 1);

      go_to(2500);
      check_one("pre_rst_x", 0, x0, 449);
      #2 rst = 1'b1;
      #1;
      check_one("async_rst_hs", 0, hs0, 1);
      check_one("async_rst_de", 0, de0, 0);
      check_one("async_rst_x", 0, x0, 0);
      check_one("async_rst_y", 0, y0, 0);
      check_one("async_rst_hsd", 0, hsd0, 1);
      check_one("async_rst_ce", 2, ce2, 0);
      check_one("async_rst_hs", 2, hs2, 0);
      check_one("async_rst_ded", 1, ded1, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      go_to(1);
      check_one("restart_fs_early", 0, fs0, 0);
      check_one("restart_fs", 2, fs2, 1);
      go_to(2);
      check_one("restart_fs", 0, fs0, 1);
      check_one("restart_fs", 1, fs1, 1);
      go_to(8);
      check_one("restart_ded", 1, ded1, 1);
      go_to(700);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
